soc_ahb3_ext_slave_mem: RTL
===========================

SOC_AHB3_EXT_SLAVE_MEM -- requirements
Module: soc_ahb3_ext_slave_mem

Interface
REQ-001 SHALL have parameter PLEN, default 32, meaning address width in bits.
REQ-002 SHALL have parameter XLEN, default 32, meaning data width in bits; only 32 is supported.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words of backing storage; power of two.
REQ-004 SHALL have parameter BASE, default 32'h8000_0000, meaning byte address of word 0, aligned to DEPTH*4.
REQ-005 SHALL have parameter WAIT_STATES, default 2, meaning stall cycles per active transfer (range 0..15).
REQ-006 SHALL have ports (name direction width meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ahb3_ext_hsel_i  in  1  slave select.
- ahb3_ext_haddr_i  in  PLEN  byte address.
- ahb3_ext_hwdata_i  in  XLEN  write data (data phase).
- ahb3_ext_hwrite_i  in  1  1=write.
- ahb3_ext_hsize_i  in  3  0=byte, 1=half, 2=word.
- ahb3_ext_hburst_i  in  3  burst type; ignored.
- ahb3_ext_hprot_i  in  4  protection; ignored.
- ahb3_ext_htrans_i  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- ahb3_ext_hmastlock_i  in  1  locked; ignored.
- ahb3_ext_hready_i  in  1  bus HREADY (previous transfer done).
- ahb3_ext_hrdata_o  out  XLEN  read data.
- ahb3_ext_hready_o  out  1  transfer done.
- ahb3_ext_hresp_o  out  1  0=OKAY, 1=ERROR.

Function
REQ-007 SHALL accept an address phase only when hsel_i & hready_i & htrans_i in {NONSEQ, SEQ}; SHALL then register haddr, hwrite and hsize for the data phase.
REQ-008 SHALL treat IDLE, BUSY or unselected cycles as zero-wait OKAY: hready_o=1, hresp_o=0, no storage access.
REQ-009 SHALL use states IDLE, WAIT, ERR1 and ERR2.
- IDLE: accepted good transfer goes to WAIT if the wait counter is nonzero, else completes in IDLE; accepted bad transfer goes to ERR1.
- WAIT: decrements the counter; goes to IDLE when the counter reaches 0.
- ERR1 goes to ERR2; ERR2 goes to IDLE, or directly accepts a new address phase.
REQ-010 SHALL flag a transfer as bad when:
- the address is outside [BASE, BASE+DEPTH*4); or
- hsize_i > 2; or
- the address is misaligned to hsize (half: addr[0]!=0; word: addr[1:0]!=0).
REQ-011 SHALL signal ERROR as two cycles: ERR1 with hready_o=0, hresp_o=1, then ERR2 with hready_o=1, hresp_o=1; errored writes SHALL NOT modify storage.
REQ-012 SHALL hold hready_o=0, hresp_o=0 in every WAIT cycle; the completing data-phase cycle SHALL have hready_o=1, hresp_o=0.
REQ-013 SHALL commit writes on the completing data-phase cycle, using hwdata_i of that cycle and byte lanes from the registered addr[1:0] and hsize.
- Byte: one lane.
- Half: lanes {1,0} or {3,2}.
- Word: all four lanes.
REQ-014 SHALL drive hrdata_o with the full addressed word on the completing cycle of a read (unselected lanes included). The word SHALL reflect every write completed earlier, including a write completing the immediately preceding cycle.
REQ-015 SHALL drive hrdata_o with its last value outside read completion cycles (hold, no X).
REQ-016 SHALL accept a new address phase in the same cycle it completes the previous one (pipelined back-to-back) with no bubble.
REQ-017 SHALL map word index as (haddr-BASE)[log2(DEPTH)+1:2].

Reset
REQ-018 SHALL, while rst=1, asynchronously force:
- state=IDLE, wait counter=0;
- hready_o=1, hresp_o=0, hrdata_o=0;
- registered phase discarded.
REQ-019 SHALL discard any pending write if reset is asserted mid-transfer; storage contents SHALL NOT be reset.

Configuration
REQ-020 SHALL honour macro SOC_AHB3_EXT_SLAVE_WAIT_EN.
- Defined: each good accepted transfer inserts exactly WAIT_STATES WAIT cycles before completion.
- Undefined: the WAIT state and counter are not compiled; WAIT_STATES is ignored and every good transfer completes in the cycle after its address phase.
- Error timing is identical in both builds.

Verification
REQ-021 SHALL pass, WAIT_EN undefined: word write 32'hDEAD_BEEF to BASE+4, then read BASE+4 -> hrdata_o=32'hDEAD_BEEF, hready_o=1 every cycle.
REQ-022 SHALL pass, WAIT_EN defined, WAIT_STATES=2: NONSEQ read -> exactly 2 cycles hready_o=0, then hready_o=1, hresp_o=0.
REQ-023 SHALL pass: word write 32'h1122_3344 to BASE, then byte write 8'hAA to BASE+2 (lane 2), then read BASE -> 32'h11AA_3344.
REQ-024 SHALL pass: write to BASE+DEPTH*4 -> ERR1 (hready_o=0, hresp_o=1), then ERR2 (hready_o=1, hresp_o=1), storage unchanged. Half write to BASE+1 -> same ERROR pair.
REQ-025 SHALL pass: back-to-back write BASE+8 = 32'h5A5A_5A5A then read BASE+8 with no idle cycle -> 32'h5A5A_5A5A.
REQ-026 SHALL pass: rst asserted during a WAIT cycle of a write -> hready_o=1, hresp_o=0 immediately; a later read of that word returns its pre-write value.

Source files
------------

// File: rtl/soc_ahb3_ext_slave_mem.sv
// rtl/soc_ahb3_ext_slave_mem.sv - AHB3 slave memory with error response; SOC_AHB3_EXT_SLAVE_WAIT_EN enables wait states
module soc_ahb3_ext_slave_mem #(
    parameter int              PLEN        = 32,
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 1024,
    parameter logic [PLEN-1:0] BASE        = 32'h8000_0000,
    parameter int              WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ahb3_ext_hsel_i,
    input  logic [PLEN-1:0] ahb3_ext_haddr_i,
    input  logic [XLEN-1:0] ahb3_ext_hwdata_i,
    input  logic            ahb3_ext_hwrite_i,
    input  logic [2:0]      ahb3_ext_hsize_i,
    input  logic [2:0]      ahb3_ext_hburst_i,
    input  logic [3:0]      ahb3_ext_hprot_i,
    input  logic [1:0]      ahb3_ext_htrans_i,
    input  logic            ahb3_ext_hmastlock_i,
    input  logic            ahb3_ext_hready_i,
    output logic [XLEN-1:0] ahb3_ext_hrdata_o,
    output logic            ahb3_ext_hready_o,
    output logic            ahb3_ext_hresp_o
);
    localparam int AW = $clog2(DEPTH) + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
`ifdef SOC_AHB3_EXT_SLAVE_WAIT_EN
        , S_WAIT = 2'd1
`endif
    } state_t;

    state_t          state_q, state_d;
    logic            pend_q, pend_d;
    logic            write_q, write_d;
    logic [1:0]      size_q, size_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     hrdata_q;
`ifdef SOC_AHB3_EXT_SLAVE_WAIT_EN
    logic [3:0]      cnt_q, cnt_d;
`endif

    logic [31:0]     mem_q [DEPTH];
    logic            accept_ok, accept, bad, complete;
    logic [3:0]      be;

    logic unused_ok;
    assign unused_ok = ^{ahb3_ext_hburst_i, ahb3_ext_hprot_i, ahb3_ext_hmastlock_i,
                         ahb3_ext_htrans_i[0]};

    // Range check by upper address bits relies on BASE being DEPTH*4 aligned
    always_comb begin
        bad = (ahb3_ext_haddr_i[PLEN-1:AW] != BASE[PLEN-1:AW]) || (ahb3_ext_hsize_i > 3'd2);
        if (ahb3_ext_hsize_i == 3'd1 && ahb3_ext_haddr_i[0])
            bad = 1'b1;
        if (ahb3_ext_hsize_i == 3'd2 && ahb3_ext_haddr_i[1:0] != 2'b00)
            bad = 1'b1;
    end

    always_comb begin
        state_d           = state_q;
        pend_d            = pend_q;
        write_d           = write_q;
        size_d            = size_q;
        addr_d            = addr_q;
`ifdef SOC_AHB3_EXT_SLAVE_WAIT_EN
        cnt_d             = cnt_q;
`endif
        ahb3_ext_hready_o = 1'b1;
        ahb3_ext_hresp_o  = 1'b0;
        accept_ok         = 1'b0;
        complete          = 1'b0;
        case (state_q)
            S_IDLE: begin
                complete  = pend_q;
                pend_d    = 1'b0;
                accept_ok = 1'b1;
            end
`ifdef SOC_AHB3_EXT_SLAVE_WAIT_EN
            S_WAIT: begin
                ahb3_ext_hready_o = 1'b0;
                cnt_d             = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = S_IDLE;
            end
`endif
            S_ERR1: begin
                ahb3_ext_hready_o = 1'b0;
                ahb3_ext_hresp_o  = 1'b1;
                state_d           = S_ERR2;
            end
            S_ERR2: begin
                ahb3_ext_hresp_o = 1'b1;
                state_d          = S_IDLE;
                accept_ok        = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        accept = accept_ok && ahb3_ext_hsel_i && ahb3_ext_hready_i && ahb3_ext_htrans_i[1];
        if (accept) begin
            if (bad) begin
                state_d = S_ERR1;
            end else begin
                pend_d  = 1'b1;
                write_d = ahb3_ext_hwrite_i;
                size_d  = ahb3_ext_hsize_i[1:0];
                addr_d  = ahb3_ext_haddr_i[AW-1:0];
`ifdef SOC_AHB3_EXT_SLAVE_WAIT_EN
                if (WAIT_STATES != 0) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end
`endif
            end
        end
    end

    always_comb begin
        case (size_q)
            2'd0:    be = 4'b0001 << addr_q[1:0];
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Asynchronous read so a write committed on the previous edge is visible
    assign ahb3_ext_hrdata_o = (complete && !write_q) ? mem_q[addr_q[AW-1:2]] : hrdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pend_q   <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            hrdata_q <= '0;
`ifdef SOC_AHB3_EXT_SLAVE_WAIT_EN
            cnt_q    <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            write_q  <= write_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            hrdata_q <= ahb3_ext_hrdata_o;
`ifdef SOC_AHB3_EXT_SLAVE_WAIT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (complete && write_q) begin
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem_q[addr_q[AW-1:2]][8*i +: 8] <= ahb3_ext_hwdata_i[8*i +: 8];
        end
    end
endmodule
